// File: rtl/hdmi_frame_timing_detector.sv
// Pixel-domain HDMI timing detector: pixel coordinates, per-frame active size
// measurement and lock after LOCK_FRAMES identical good frames.
module hdmi_frame_timing_detector #(
    parameter int unsigned X_W         = 12,
    parameter int unsigned Y_W         = 11,
    parameter int unsigned LOCK_FRAMES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           de_in,
    input  logic           vsync_in,
    output logic           de_out,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           frame_start,
    output logic           frame_end,
    output logic [X_W-1:0] active_width,
    output logic [Y_W-1:0] active_height,
    output logic           locked
);

    localparam int unsigned CNT_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [X_W-1:0] XMax = '1;
    localparam logic [Y_W-1:0] YMax = '1;
    localparam logic [CNT_W-1:0] CntLock = CNT_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

    state_e           state_q, state_d;
    logic             de_q, vs_q;
    logic [X_W-1:0]   cx_q, cx_d;
    logic [Y_W-1:0]   cy_q, cy_d;
    logic [X_W-1:0]   ref_w_q, ref_w_d;
    logic             first_q, first_d;
    logic             bad_q, bad_d;
    logic             skip_q, skip_d;
    logic             started_q, started_d;
    logic             pend_q, pend_d;
    logic             de_out_q;
    logic [X_W-1:0]   pix_x_q, pix_x_d;
    logic [Y_W-1:0]   pix_y_q, pix_y_d;
    logic             fs_q, fs_d;
    logic             fe_q, fe_d;
    logic [X_W-1:0]   aw_q, aw_d;
    logic [Y_W-1:0]   ah_q, ah_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic           de_rise, de_fall, vs_rise, open_line, line_close, frame_good;
    logic [X_W-1:0] frame_w;
    logic [Y_W-1:0] frame_h;

    always_comb begin
        de_rise    = de_in & ~de_q;
        de_fall    = ~de_in & de_q;
        vs_rise    = vsync_in & ~vs_q;
        open_line  = vs_rise & de_in & de_q;
        line_close = de_fall & ~skip_q;

        cx_d      = cx_q;
        cy_d      = cy_q;
        ref_w_d   = ref_w_q;
        first_d   = first_q;
        bad_d     = bad_q;
        skip_d    = skip_q;
        started_d = started_q;
        pend_d    = 1'b0;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        fs_d      = pend_q;
        fe_d      = 1'b0;
        aw_d      = aw_q;
        ah_d      = ah_q;
        cnt_d     = cnt_q;
        state_d   = state_q;

        if (de_fall) begin
            skip_d = 1'b0;
        end

        if (line_close) begin
            if (cy_q == YMax) begin
                bad_d = 1'b1;
            end else begin
                cy_d = cy_q + Y_W'(1);
            end
            if (!first_q) begin
                ref_w_d = cx_q;
                first_d = 1'b1;
            end else if (cx_q != ref_w_q) begin
                bad_d = 1'b1;
            end
        end

        // Measurement includes a line closing on the same edge as VSYNC.
        frame_w    = ref_w_d;
        frame_h    = cy_d;
        frame_good = ~bad_d & first_d & ~open_line;

        if (vs_rise) begin
            fe_d      = 1'b1;
            cy_d      = '0;
            bad_d     = 1'b0;
            first_d   = 1'b0;
            started_d = 1'b0;
            skip_d    = open_line;
            if (!frame_good) begin
                state_d = StSearch;
                cnt_d   = '0;
            end else if (state_q == StSearch || frame_w != aw_q || frame_h != ah_q) begin
                aw_d    = frame_w;
                ah_d    = frame_h;
                cnt_d   = CNT_W'(1);
                state_d = (LOCK_FRAMES <= 1) ? StLocked : StTrack;
            end else begin
                if (cnt_q < CntLock) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_d >= CntLock) begin
                    state_d = StLocked;
                end
            end
        end

        if (de_in) begin
            pix_y_d = vs_rise ? '0 : cy_q;
            pix_x_d = de_rise ? '0 : cx_q;
            if (pix_x_d == XMax) begin
                cx_d = XMax;
                if (!skip_d) begin
                    bad_d = 1'b1;
                end
            end else begin
                cx_d = pix_x_d + X_W'(1);
            end
        end

        // Defer the start flag one cycle when it would collide with frame_end.
        if (de_rise && !started_d) begin
            started_d = 1'b1;
            if (vs_rise || fe_q) begin
                pend_d = 1'b1;
            end else begin
                fs_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StSearch;
            de_q      <= 1'b0;
            vs_q      <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            ref_w_q   <= '0;
            first_q   <= 1'b0;
            bad_q     <= 1'b0;
            skip_q    <= 1'b0;
            started_q <= 1'b0;
            pend_q    <= 1'b0;
            de_out_q  <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            fs_q      <= 1'b0;
            fe_q      <= 1'b0;
            aw_q      <= '0;
            ah_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            de_q      <= de_in;
            vs_q      <= vsync_in;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            ref_w_q   <= ref_w_d;
            first_q   <= first_d;
            bad_q     <= bad_d;
            skip_q    <= skip_d;
            started_q <= started_d;
            pend_q    <= pend_d;
            de_out_q  <= de_in;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            fs_q      <= fs_d;
            fe_q      <= fe_d;
            aw_q      <= aw_d;
            ah_q      <= ah_d;
            cnt_q     <= cnt_d;
        end
    end

    assign de_out        = de_out_q;
    assign pix_x         = pix_x_q;
    assign pix_y         = pix_y_q;
    assign frame_start   = fs_q;
    assign frame_end     = fe_q;
    assign active_width  = aw_q;
    assign active_height = ah_q;
    assign locked        = (state_q == StLocked);

endmodule

// File: tb/tb_hdmi_frame_timing_detector.sv
// Directed bench for hdmi_frame_timing_detector with LOCK_FRAMES = 2.
module tb_hdmi_frame_timing_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_in;
    logic        vsync_in;
    logic        de_out;
    logic [11:0] pix_x;
    logic [10:0] pix_y;
    logic        frame_start;
    logic        frame_end;
    logic [11:0] active_width;
    logic [10:0] active_height;
    logic        locked;

    int checks = 0;
    int errors = 0;

    hdmi_frame_timing_detector #(
        .X_W        (12),
        .Y_W        (11),
        .LOCK_FRAMES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .de_in        (de_in),
        .vsync_in     (vsync_in),
        .de_out       (de_out),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .active_width (active_width),
        .active_height(active_height),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_de_out"}, de_out, 0);
        chk({tag, "_pix_x"}, pix_x, 0);
        chk({tag, "_pix_y"}, pix_y, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_fe"}, frame_end, 0);
        chk({tag, "_aw"}, active_width, 0);
        chk({tag, "_ah"}, active_height, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    // n pixels on line y, then 2 blanking cycles.
    task automatic line(input int n, input int y, input bit first);
        de_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick;
            chk("line_de_out", de_out, 1);
            chk("line_pix_x", pix_x, i);
            chk("line_pix_y", pix_y, y);
            chk("line_fs", frame_start, (first && i == 0) ? 1 : 0);
            chk("line_fe", frame_end, 0);
        end
        de_in = 1'b0;
        tick;
        chk("line_de_out_low", de_out, 0);
        tick;
    endtask

    task automatic frame3(input int w0, input int w1, input int w2);
        line(w0, 0, 1'b1);
        line(w1, 1, 1'b0);
        line(w2, 2, 1'b0);
    endtask

    task automatic vs_close(input int ew, input int eh, input bit el);
        vsync_in = 1'b1;
        tick;
        chk("close_fe", frame_end, 1);
        chk("close_fs", frame_start, 0);
        chk("close_aw", active_width, ew);
        chk("close_ah", active_height, eh);
        chk("close_locked", locked, el);
        tick;
        chk("close_fe_low", frame_end, 0);
        chk("close_locked_hold", locked, el);
        vsync_in = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        rst      = 1'b1;
        de_in    = 1'b0;
        vsync_in = 1'b0;
        tick;
        tick;
        chk_all_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("idle_fs", frame_start, 0);
            chk("idle_fe", frame_end, 0);
            chk("idle_locked", locked, 0);
        end

        // Lock on a 4x3 stream: locked rises at the second close.
        frame3(4, 4, 4);
        vs_close(4, 3, 0);
        frame3(4, 4, 4);
        vs_close(4, 3, 1);
        frame3(4, 4, 4);
        vs_close(4, 3, 1);

        // Bad line width drops lock, size held; two good frames relock.
        frame3(4, 5, 4);
        vs_close(4, 3, 0);
        frame3(4, 4, 4);
        vs_close(4, 3, 0);
        frame3(4, 4, 4);
        vs_close(4, 3, 1);

        // Width change to 6.
        frame3(6, 6, 6);
        vs_close(6, 3, 0);
        frame3(6, 6, 6);
        vs_close(6, 3, 1);

        // VSYNC rising mid-line: bad frame, remainder of line discarded.
        line(6, 0, 1'b1);
        line(6, 1, 1'b0);
        de_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("midline_pix_x", pix_x, i);
            chk("midline_pix_y", pix_y, 2);
        end
        vsync_in = 1'b1;
        tick;
        chk("midline_fe", frame_end, 1);
        chk("midline_fs", frame_start, 0);
        chk("midline_locked", locked, 0);
        chk("midline_aw", active_width, 6);
        chk("midline_ah", active_height, 3);
        tick;
        chk("midline_fe_low", frame_end, 0);
        chk("midline_fs_low", frame_start, 0);
        vsync_in = 1'b0;
        tick;
        chk("midline_fs_low2", frame_start, 0);
        de_in = 1'b0;
        tick;
        tick;

        // Good frame, closed by a VSYNC edge coinciding with the next DE rise.
        frame3(6, 6, 6);
        vsync_in = 1'b1;
        de_in    = 1'b1;
        tick;
        chk("same_fe", frame_end, 1);
        chk("same_fs", frame_start, 0);
        chk("same_de_out", de_out, 1);
        chk("same_pix_x", pix_x, 0);
        chk("same_pix_y", pix_y, 0);
        chk("same_aw", active_width, 6);
        chk("same_ah", active_height, 3);
        chk("same_locked", locked, 0);
        tick;
        chk("same_fe_low", frame_end, 0);
        chk("same_fs_late", frame_start, 1);
        chk("same_pix_x1", pix_x, 1);
        vsync_in = 1'b0;
        for (int i = 2; i < 6; i++) begin
            tick;
            chk("same_pix_x_run", pix_x, i);
            chk("same_fs_low", frame_start, 0);
        end
        de_in = 1'b0;
        tick;
        tick;
        line(6, 1, 1'b0);
        line(6, 2, 1'b0);
        vs_close(6, 3, 1);

        // Asynchronous reset mid-frame while locked.
        line(6, 0, 1'b1);
        de_in = 1'b1;
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        de_in = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        frame3(6, 6, 6);
        vs_close(6, 3, 0);
        frame3(6, 6, 6);
        vs_close(6, 3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
